// File: rtl/anna_pkg.sv
// Shared constants for the ANNA execute stage: widths, opcodes, R-type function codes
// and the sign-extension helpers used by the datapath.
package anna_pkg;

  localparam int unsigned WORD_SIZE = 16;
  localparam int unsigned REG_COUNT = 8;
  localparam int unsigned REG_AW    = 3;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_JALR = 4'b0010;
  localparam logic [3:0] OP_IN   = 4'b0011;
  localparam logic [3:0] OP_OUT  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_SHF  = 4'b0110;
  localparam logic [3:0] OP_LW   = 4'b0111;
  localparam logic [3:0] OP_SW   = 4'b1000;
  localparam logic [3:0] OP_LLI  = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;
  localparam logic [3:0] OP_BEZ  = 4'b1011;
  localparam logic [3:0] OP_BNZ  = 4'b1100;
  localparam logic [3:0] OP_BGZ  = 4'b1101;
  localparam logic [3:0] OP_BLZ  = 4'b1110;

  localparam logic [2:0] F_ADD = 3'b000;
  localparam logic [2:0] F_SUB = 3'b001;
  localparam logic [2:0] F_AND = 3'b010;
  localparam logic [2:0] F_OR  = 3'b011;
  localparam logic [2:0] F_NOT = 3'b100;

  function automatic logic [WORD_SIZE-1:0] sext6(input logic [5:0] v);
    return {{(WORD_SIZE-6){v[5]}}, v};
  endfunction

  function automatic logic [WORD_SIZE-1:0] sext8(input logic [7:0] v);
    return {{(WORD_SIZE-8){v[7]}}, v};
  endfunction

endpackage

// File: rtl/anna_register_file.sv
// Architectural register file: two combinational read ports, one synchronous write port.
// r0 is never written and always reads as zero; a disabled read port returns zero.
module register_file #(
  parameter int unsigned REG_COUNT = 8,
  parameter int unsigned WORD_SIZE = 16,
  localparam int unsigned AW = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 r_en1,
  input  logic [AW-1:0]        reg1,
  output logic [WORD_SIZE-1:0] r_data1,
  input  logic                 r_en2,
  input  logic [AW-1:0]        reg2,
  output logic [WORD_SIZE-1:0] r_data2,
  input  logic                 w_en,
  input  logic [AW-1:0]        w_addr,
  input  logic [WORD_SIZE-1:0] w_data
);

  logic [WORD_SIZE-1:0] regs [REG_COUNT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= '0;
    end else if (w_en && (w_addr != '0)) begin
      regs[w_addr] <= w_data;
    end
  end

  // No write bypass: a same-cycle read sees the pre-write value.
  assign r_data1 = (r_en1 && (reg1 != '0)) ? regs[reg1] : '0;
  assign r_data2 = (r_en2 && (reg2 != '0)) ? regs[reg2] : '0;

endmodule

// File: rtl/anna_exec.sv
// ANNA execute stage: combinational ALU, next-PC and address generation over the
// register file, with registered out-port, sticky halt and writeback on the en edge.
module anna_exec
  import anna_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [3:0]           opcode,
  input  logic [2:0]           rd,
  input  logic [2:0]           rs1,
  input  logic [2:0]           rs2,
  input  logic [2:0]           func,
  input  logic [5:0]           imm6,
  input  logic [7:0]           imm8,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] mem_r_data,
  input  logic [WORD_SIZE-1:0] in_data,
  output logic [WORD_SIZE-1:0] pc_prime,
  output logic [WORD_SIZE-1:0] rd_prime,
  output logic [WORD_SIZE-1:0] mem_addr_o,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_data,
  output logic                 halt
);

  logic [WORD_SIZE-1:0] r_data1;
  logic [WORD_SIZE-1:0] r_data2;
  logic [REG_AW-1:0]    reg2_sel;
  logic [REG_AW-1:0]    w_addr_c;
  logic                 w_req_c;
  logic                 w_en;
  logic [WORD_SIZE-1:0] imm6_s;
  logic [WORD_SIZE-1:0] pc_inc;
  logic [WORD_SIZE-1:0] br_target;
  logic [WORD_SIZE-1:0] shf_res;
  logic [5:0]           neg_amt;

  assign reg2_sel   = (opcode == OP_ADD) ? rs2 : rd;
  assign imm6_s     = sext6(imm6);
  assign pc_inc     = pc + WORD_SIZE'(1);
  assign br_target  = pc_inc + sext8(imm8);
  assign mem_addr_o = r_data1 + imm6_s;
  assign w_en       = en && !halt && w_req_c;

  register_file #(
    .REG_COUNT(REG_COUNT),
    .WORD_SIZE(WORD_SIZE)
  ) u_regs (
    .clk    (clk),
    .reset  (reset),
    .r_en1  (1'b1),
    .reg1   (rs1),
    .r_data1(r_data1),
    .r_en2  (1'b1),
    .reg2   (reg2_sel),
    .r_data2(r_data2),
    .w_en   (w_en),
    .w_addr (w_addr_c),
    .w_data (rd_prime)
  );

  // Signed shift amount: positive = logical left, negative = arithmetic right; >=16 saturates.
  assign neg_amt = 6'(-imm6);

  always_comb begin
    shf_res = '0;
    if (!imm6[5]) begin
      if (!imm6[4]) shf_res = r_data1 << imm6[3:0];
    end else begin
      shf_res = {WORD_SIZE{r_data1[WORD_SIZE-1]}};
      if (neg_amt[5:4] == 2'b00) shf_res = WORD_SIZE'($signed(r_data1) >>> neg_amt[3:0]);
    end
  end

  // Result, writeback target and next-PC selection.
  always_comb begin
    pc_prime = pc_inc;
    rd_prime = r_data2;
    w_req_c  = 1'b0;
    w_addr_c = rd;
    case (opcode)
      OP_ADD: begin
        w_req_c = 1'b1;
        case (func)
          F_ADD:   rd_prime = r_data1 + r_data2;
          F_SUB:   rd_prime = r_data1 - r_data2;
          F_AND:   rd_prime = r_data1 & r_data2;
          F_OR:    rd_prime = r_data1 | r_data2;
          F_NOT:   rd_prime = ~r_data1;
          default: w_req_c  = 1'b0;
        endcase
      end
      OP_JALR: begin
        pc_prime = r_data2;
        rd_prime = pc_inc;
        w_addr_c = rs1;
        w_req_c  = 1'b1;
      end
      OP_IN:   begin rd_prime = in_data;                w_req_c = 1'b1; end
      OP_ADDI: begin rd_prime = r_data1 + imm6_s;       w_req_c = 1'b1; end
      OP_SHF:  begin rd_prime = shf_res;                w_req_c = 1'b1; end
      OP_LW:   begin rd_prime = mem_r_data;             w_req_c = 1'b1; end
      OP_LLI:  begin rd_prime = sext8(imm8);            w_req_c = 1'b1; end
      OP_LUI:  begin rd_prime = {imm8, r_data2[7:0]};   w_req_c = 1'b1; end
      OP_BEZ:  if (r_data2 == '0) pc_prime = br_target;
      OP_BNZ:  if (r_data2 != '0) pc_prime = br_target;
      OP_BGZ:  if (!r_data2[WORD_SIZE-1] && (r_data2 != '0)) pc_prime = br_target;
      OP_BLZ:  if (r_data2[WORD_SIZE-1]) pc_prime = br_target;
      default: ;
    endcase
  end

  // Out port and halt; once halted nothing executes until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      if (en && !halt && (opcode == OP_OUT)) begin
        if (rd == '0) begin
          halt <= 1'b1;
        end else begin
          out_valid <= 1'b1;
          out_data  <= r_data2;
        end
      end
    end
  end

endmodule

// File: tb/tb_anna_exec.sv
// Self-checking bench for anna_exec: directed scenarios plus randomized instructions
// compared against an instruction-level reference model of the ANNA execute stage.
module tb_anna_exec;

  logic        clk;
  logic        reset;
  logic        en;
  logic [3:0]  opcode;
  logic [2:0]  rd, rs1, rs2, func;
  logic [5:0]  imm6;
  logic [7:0]  imm8;
  logic [15:0] pc, mem_r_data, in_data;
  logic [15:0] pc_prime, rd_prime, mem_addr_o, out_data;
  logic        out_valid, halt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_regs [8];
  logic        m_halt, m_ov;
  logic [15:0] m_od;

  anna_exec dut (
    .clk(clk), .reset(reset), .en(en), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .func(func), .imm6(imm6), .imm8(imm8), .pc(pc), .mem_r_data(mem_r_data),
    .in_data(in_data), .pc_prime(pc_prime), .rd_prime(rd_prime), .mem_addr_o(mem_addr_o),
    .out_valid(out_valid), .out_data(out_data), .halt(halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rr(input logic [2:0] i);
    return (i == 3'd0) ? 16'h0000 : m_regs[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_halt = 1'b0;
    m_ov   = 1'b0;
    m_od   = 16'h0000;
  endtask

  // Read a register without side effects: sw with en low exposes R(Rd) on rd_prime.
  task automatic peek(input logic [2:0] r, output logic [15:0] v);
    @(negedge clk);
    en = 1'b0; opcode = 4'b1000; rd = r;
    #1 v = rd_prime;
  endtask

  // One instruction: model predicts outputs, DUT is driven and compared.
  task automatic do_instr(input logic e, input logic [3:0] op, input logic [2:0] d,
                          input logic [2:0] s1, input logic [2:0] s2, input logic [2:0] f,
                          input logic [5:0] i6, input logic [7:0] i8, input logic [15:0] p,
                          input logic [15:0] md, input logic [15:0] id);
    logic [15:0] a, b, dv, epc, eres, eaddr;
    logic [2:0]  wa;
    bit          wr, chk;
    int          sh, sa;
    a = rr(s1); b = rr(s2); dv = rr(d);
    epc = 16'(int'(p) + 1); eres = 16'h0000; wr = 0; chk = 0; wa = d;
    eaddr = 16'(int'(a) + int'($signed(i6)));
    case (op)
      4'b0000: begin
        chk = (f <= 3'd4); wr = chk;
        case (f)
          3'd0: eres = 16'(int'(a) + int'(b));
          3'd1: eres = 16'(int'(a) - int'(b));
          3'd2: eres = a & b;
          3'd3: eres = a | b;
          3'd4: eres = ~a;
          default: ;
        endcase
      end
      4'b0010: begin epc = dv; eres = 16'(int'(p) + 1); wr = 1; wa = s1; chk = 1; end
      4'b0011: begin eres = id; wr = 1; chk = 1; end
      4'b0101: begin eres = eaddr; wr = 1; chk = 1; end
      4'b0110: begin
        sh = int'($signed(i6)); sa = int'($signed(a));
        if (sh >= 0) eres = (sh >= 16) ? 16'h0000 : 16'(int'(a) << sh);
        else if (-sh >= 16) eres = (sa < 0) ? 16'hFFFF : 16'h0000;
        else eres = 16'(sa >>> (-sh));
        wr = 1; chk = 1;
      end
      4'b0111: begin eres = md; wr = 1; chk = 1; end
      4'b1000: begin eres = dv; chk = 1; end
      4'b1001: begin eres = 16'(int'($signed(i8))); wr = 1; chk = 1; end
      4'b1010: begin eres = {i8, dv[7:0]}; wr = 1; chk = 1; end
      4'b1011: if (dv == 16'd0) epc = 16'(int'(p) + 1 + int'($signed(i8)));
      4'b1100: if (dv != 16'd0) epc = 16'(int'(p) + 1 + int'($signed(i8)));
      4'b1101: if (int'($signed(dv)) > 0) epc = 16'(int'(p) + 1 + int'($signed(i8)));
      4'b1110: if (int'($signed(dv)) < 0) epc = 16'(int'(p) + 1 + int'($signed(i8)));
      default: ;
    endcase

    @(negedge clk);
    en = e; opcode = op; rd = d; rs1 = s1; rs2 = s2; func = f;
    imm6 = i6; imm8 = i8; pc = p; mem_r_data = md; in_data = id;
    #1;
    n_tests++;
    if (pc_prime !== epc) begin
      n_fail++; $display("FAIL pc_prime op=%b: got %h expected %h", op, pc_prime, epc);
    end
    if (chk) begin
      n_tests++;
      if (rd_prime !== eres) begin
        n_fail++; $display("FAIL rd_prime op=%b: got %h expected %h", op, rd_prime, eres);
      end
    end
    if (op == 4'b0111 || op == 4'b1000) begin
      n_tests++;
      if (mem_addr_o !== eaddr) begin
        n_fail++; $display("FAIL mem_addr op=%b: got %h expected %h", op, mem_addr_o, eaddr);
      end
    end

    @(posedge clk);
    #1;
    m_ov = 1'b0;
    if (e && !m_halt) begin
      if (wr && wa != 3'd0) m_regs[wa] = eres;
      if (op == 4'b0100) begin
        if (d == 3'd0) m_halt = 1'b1;
        else begin m_ov = 1'b1; m_od = dv; end
      end
    end
    n_tests++;
    if (out_valid !== m_ov) begin
      n_fail++; $display("FAIL out_valid: got %b expected %b", out_valid, m_ov);
    end
    n_tests++;
    if (out_data !== m_od) begin
      n_fail++; $display("FAIL out_data: got %h expected %h", out_data, m_od);
    end
    n_tests++;
    if (halt !== m_halt) begin
      n_fail++; $display("FAIL halt: got %b expected %b", halt, m_halt);
    end
    en = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v;
    reset = 1'b1; en = 1'b1; opcode = 4'b0101; rd = 3'd1; rs1 = 3'd0; rs2 = 3'd0;
    func = 3'd0; imm6 = 6'd5; imm8 = 8'd0; pc = 16'd0; mem_r_data = 16'd0; in_data = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (halt !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_outputs: got halt=%b ov=%b od=%h expected 0/0/0000",
                         halt, out_valid, out_data);
    end
    @(negedge clk);
    reset = 1'b0; en = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      peek(3'(i), v);
      n_tests++;
      if (v !== 16'h0000) begin
        n_fail++; $display("FAIL reset_reg r%0d: got %h expected 0000", i, v);
      end
    end
  endtask

  task automatic test_alu();
    logic [15:0] v;
    do_instr(1, 4'b0101, 3'd1, 3'd0, 3'd0, 3'd0, 6'd5, 8'd0, 16'h0000, 16'd0, 16'd0);
    peek(3'd1, v);
    n_tests++;
    if (v !== 16'h0005) begin n_fail++; $display("FAIL addi_r1: got %h expected 0005", v); end
    do_instr(1, 4'b0101, 3'd1, 3'd0, 3'd0, 3'd0, 6'd3, 8'd0, 16'h0001, 16'd0, 16'd0);
    do_instr(1, 4'b0101, 3'd2, 3'd0, 3'd0, 3'd0, 6'd5, 8'd0, 16'h0002, 16'd0, 16'd0);
    do_instr(1, 4'b0000, 3'd3, 3'd1, 3'd2, 3'd1, 6'd0, 8'd0, 16'h0003, 16'd0, 16'd0);
    peek(3'd3, v);
    n_tests++;
    if (v !== 16'hFFFE) begin n_fail++; $display("FAIL sub_r3: got %h expected FFFE", v); end
    do_instr(1, 4'b0000, 3'd4, 3'd3, 3'd0, 3'd4, 6'd0, 8'd0, 16'h0004, 16'd0, 16'd0);
    peek(3'd4, v);
    n_tests++;
    if (v !== 16'h0001) begin n_fail++; $display("FAIL not_r4: got %h expected 0001", v); end
    do_instr(1, 4'b0101, 3'd0, 3'd0, 3'd0, 3'd0, 6'd7, 8'd0, 16'h0005, 16'd0, 16'd0);
    peek(3'd0, v);
    n_tests++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL r0_zero: got %h expected 0000", v); end
    do_instr(1, 4'b1001, 3'd1, 3'd0, 3'd0, 3'd0, 6'd0, 8'h12, 16'h0006, 16'd0, 16'd0);
    do_instr(1, 4'b1010, 3'd1, 3'd0, 3'd0, 3'd0, 6'd0, 8'hAB, 16'h0007, 16'd0, 16'd0);
    peek(3'd1, v);
    n_tests++;
    if (v !== 16'hAB12) begin n_fail++; $display("FAIL lui_r1: got %h expected AB12", v); end
    // Same-cycle read of the register being written sees the old value.
    do_instr(1, 4'b0101, 3'd1, 3'd1, 3'd0, 3'd0, 6'd1, 8'd0, 16'h0008, 16'd0, 16'd0);
    do_instr(1, 4'b0101, 3'd1, 3'd1, 3'd0, 3'd0, 6'd1, 8'd0, 16'h0009, 16'd0, 16'd0);
  endtask

  task automatic test_branch_jump();
    logic [15:0] v;
    do_instr(1, 4'b0101, 3'd2, 3'd0, 3'd0, 3'd0, 6'd0, 8'd0, 16'h000A, 16'd0, 16'd0);
    do_instr(1, 4'b1011, 3'd2, 3'd0, 3'd0, 3'd0, 6'd0, 8'hFE, 16'h0010, 16'd0, 16'd0);
    @(negedge clk);
    en = 1'b0; opcode = 4'b1011; rd = 3'd2; imm8 = 8'hFE; pc = 16'h0010;
    #1;
    n_tests++;
    if (pc_prime !== 16'h000F) begin n_fail++; $display("FAIL bez_taken: got %h expected 000F", pc_prime); end
    do_instr(1, 4'b0101, 3'd2, 3'd0, 3'd0, 3'd0, 6'd1, 8'd0, 16'h000B, 16'd0, 16'd0);
    @(negedge clk);
    en = 1'b0; opcode = 4'b1011; rd = 3'd2; imm8 = 8'hFE; pc = 16'h0010;
    #1;
    n_tests++;
    if (pc_prime !== 16'h0011) begin n_fail++; $display("FAIL bez_not_taken: got %h expected 0011", pc_prime); end
    do_instr(1, 4'b1001, 3'd5, 3'd0, 3'd0, 3'd0, 6'd0, 8'h00, 16'h000C, 16'd0, 16'd0);
    do_instr(1, 4'b1010, 3'd5, 3'd0, 3'd0, 3'd0, 6'd0, 8'h01, 16'h000D, 16'd0, 16'd0);
    do_instr(1, 4'b0010, 3'd5, 3'd6, 3'd0, 3'd0, 6'd0, 8'd0, 16'h0010, 16'd0, 16'd0);
    peek(3'd6, v);
    n_tests++;
    if (v !== 16'h0011) begin n_fail++; $display("FAIL jalr_link: got %h expected 0011", v); end
  endtask

  task automatic test_shift_load();
    logic [15:0] v;
    do_instr(1, 4'b1001, 3'd2, 3'd0, 3'd0, 3'd0, 6'd0, 8'h00, 16'h0020, 16'd0, 16'd0);
    do_instr(1, 4'b1010, 3'd2, 3'd0, 3'd0, 3'd0, 6'd0, 8'h80, 16'h0021, 16'd0, 16'd0);
    do_instr(1, 4'b0110, 3'd1, 3'd2, 3'd0, 3'd0, 6'h3F, 8'd0, 16'h0022, 16'd0, 16'd0);
    peek(3'd1, v);
    n_tests++;
    if (v !== 16'hC000) begin n_fail++; $display("FAIL shf_right: got %h expected C000", v); end
    do_instr(1, 4'b0111, 3'd3, 3'd1, 3'd0, 3'd0, 6'd2, 8'd0, 16'h0023, 16'hBEEF, 16'd0);
    peek(3'd3, v);
    n_tests++;
    if (v !== 16'hBEEF) begin n_fail++; $display("FAIL lw_r3: got %h expected BEEF", v); end
    @(negedge clk);
    en = 1'b0; opcode = 4'b0111; rs1 = 3'd1; imm6 = 6'd2;
    #1;
    n_tests++;
    if (mem_addr_o !== 16'hC002) begin n_fail++; $display("FAIL lw_addr: got %h expected C002", mem_addr_o); end
    // Shift boundaries: count 16 left, -16 and -32 right.
    do_instr(1, 4'b0110, 3'd4, 3'd2, 3'd0, 3'd0, 6'd16, 8'd0, 16'h0024, 16'd0, 16'd0);
    do_instr(1, 4'b0110, 3'd4, 3'd2, 3'd0, 3'd0, 6'h30, 8'd0, 16'h0025, 16'd0, 16'd0);
    do_instr(1, 4'b0110, 3'd4, 3'd2, 3'd0, 3'd0, 6'h20, 8'd0, 16'h0026, 16'd0, 16'd0);
    do_instr(1, 4'b0110, 3'd4, 3'd3, 3'd0, 3'd0, 6'd15, 8'd0, 16'h0027, 16'd0, 16'd0);
  endtask

  task automatic test_out_halt();
    logic [15:0] v;
    do_instr(1, 4'b1001, 3'd2, 3'd0, 3'd0, 3'd0, 6'd0, 8'h34, 16'h0030, 16'd0, 16'd0);
    do_instr(1, 4'b1010, 3'd2, 3'd0, 3'd0, 3'd0, 6'd0, 8'h12, 16'h0031, 16'd0, 16'd0);
    do_instr(1, 4'b0100, 3'd2, 3'd0, 3'd0, 3'd0, 6'd0, 8'd0, 16'h0032, 16'd0, 16'd0);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
      n_fail++; $display("FAIL out_pulse: got ov=%b od=%h expected 1/1234", out_valid, out_data);
    end
    do_instr(0, 4'b0000, 3'd0, 3'd0, 3'd0, 3'd7, 6'd0, 8'd0, 16'h0033, 16'd0, 16'd0);
    do_instr(1, 4'b0100, 3'd0, 3'd0, 3'd0, 3'd0, 6'd0, 8'd0, 16'h0034, 16'd0, 16'd0);
    n_tests++;
    if (halt !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL halt_set: got halt=%b ov=%b expected 1/0", halt, out_valid);
    end
    peek(3'd1, v);
    do_instr(1, 4'b0101, 3'd1, 3'd0, 3'd0, 3'd0, 6'd5, 8'd0, 16'h0035, 16'd0, 16'd0);
    do_instr(1, 4'b0100, 3'd2, 3'd0, 3'd0, 3'd0, 6'd0, 8'd0, 16'h0036, 16'd0, 16'd0);
    peek(3'd1, v);
    n_tests++;
    if (v !== 16'hC000) begin n_fail++; $display("FAIL halted_no_write: got %h expected C000", v); end
    // Reset with en high in the same cycle: reset wins and clears halt.
    @(negedge clk);
    reset = 1'b1; en = 1'b1; opcode = 4'b0101; rd = 3'd1; rs1 = 3'd0; imm6 = 6'd5;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0; en = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (halt !== 1'b0 || out_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_clears: got halt=%b od=%h expected 0/0000", halt, out_data);
    end
    peek(3'd1, v);
    n_tests++;
    if (v !== 16'h0000) begin n_fail++; $display("FAIL reset_beats_en: got %h expected 0000", v); end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [2:0]  d;
    logic [15:0] v;
    for (int n = 0; n < 400; n++) begin
      op = 4'($urandom_range(0, 15));
      d  = 3'($urandom_range(0, 7));
      if (op == 4'b0100 && d == 3'd0) d = 3'd1;
      do_instr(($urandom_range(0, 9) != 0), op, d, 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 6'($urandom),
               8'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      peek(3'(i), v);
      n_tests++;
      if (v !== rr(3'(i))) begin
        n_fail++; $display("FAIL random_reg r%0d: got %h expected %h", i, v, rr(3'(i)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_branch_jump();
    test_shift_load();
    test_out_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/anna_exec.md
# anna_exec

Execute stage of the 16-bit ANNA processor: combinational ALU plus an 8×16 register file with synchronous writeback. The control FSM presents one decoded instruction per execute strobe. The block then returns the next PC and the result value, and commits the register write on the strobe's clock edge. It sits between the decode stage and memory and I/O. Load data comes in already fetched, and the store address and data leave as outputs.

## Interface
- WORD_SIZE, 16, datapath and PC width
- REG_COUNT, 8, architectural registers (r0 hardwired 0)
- One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- en  in  1  execute strobe, one instruction per high cycle
- opcode  in  4  instr[15:12]
- rd, rs1, rs2  in  3 each  instr[11:9], [8:6], [5:3]
- func  in  3  instr[2:0], R-type function
- imm6  in  6  instr[5:0]
- imm8  in  8  instr[7:0]
- pc  in  16  address of current instruction (word-addressed)
- mem_r_data  in  16  load data for lw
- in_data  in  16  input-port value for in
- pc_prime  out  16  next PC
- rd_prime  out  16  result value (writeback data, or store data for sw)
- mem_addr_o  out  16  effective address Rs1+sext(imm6) for lw/sw
- out_valid  out  1  registered, one-cycle pulse on out
- out_data  out  16  registered, value written by out
- halt  out  1  registered, sticky

## Operation
- Arithmetic is modulo 2^16. sext() sign-extends its operand.
- Opcode 0000, R-type, Rd ← f(Rs1, Rs2):
  - func 000 add, 001 sub (Rs1−Rs2), 010 and, 011 or, 100 not Rs1.
  - func 101–111: no write.
- Opcode 0010 jalr: R(Rs1) ← pc+1; pc_prime ← R(Rd).
- Opcode 0011 in: Rd ← in_data.
- Opcode 0100 out: out_data ← R(Rd) and out_valid pulses. If rd=0, halt sets and out_valid stays 0.
- Opcode 0101 addi: Rd ← Rs1+sext(imm6).
- Opcode 0110 shf: shifts Rs1 by imm6.
  - imm6 ≥ 0: logical left by imm6.
  - imm6 < 0: arithmetic right by |imm6|.
  - Counts ≥ 16 yield 0, or sign fill for right shifts.
- Opcode 0111 lw: Rd ← mem_r_data.
- Opcode 1000 sw: rd_prime = R(Rd); no register write.
- Opcode 1001 lli: Rd ← sext(imm8).
- Opcode 1010 lui: Rd ← {imm8, R(Rd)[7:0]}.
- Branches test R(Rd) and go to pc+1+sext(imm8) when taken:
  - 1011 bez: R(Rd)=0.
  - 1100 bnz: R(Rd)≠0.
  - 1101 bgz: R(Rd)>0, signed.
  - 1110 blz: R(Rd)<0, signed.
- Opcodes 0001 and 1111 are reserved: no effect.
- pc_prime = pc+1 for every non-jump and every not-taken branch.
- Register file read ports:
  - Port 1 reads Rs1.
  - Port 2 reads Rs2 for R-type and Rd otherwise.
  - Reads of r0 return 0.
- The write address is Rs1 for jalr and Rd otherwise. Writes to r0 are discarded.

## Timing
- pc_prime, rd_prime and mem_addr_o are combinational from inputs and current register state, valid in the en cycle.
- The register write commits at the rising edge ending the en cycle. A read in the next cycle sees the new value.
- A write and a read of the same register in one cycle return the old value (no bypass).
- Reset: all registers 0, halt 0, out_valid 0, out_data 0.
- Reset beats en in the same cycle.
- Once halt=1, en is ignored (no writes, no out pulses) until reset.
- out_valid is high exactly one cycle after the out edge, then returns to 0.
- en low: no state changes. Combinational outputs still track the inputs.

## Structure
- Package anna_pkg holds:
  - Opcode localparams OP_ADD, OP_JALR, OP_IN, OP_OUT, OP_ADDI, OP_SHF, OP_LW, OP_SW, OP_LLI, OP_LUI, OP_BEZ, OP_BNZ, OP_BGZ, OP_BLZ.
  - func codes F_ADD..F_NOT.
- Sub-module register_file with:
  - parameters REG_COUNT, WORD_SIZE;
  - two combinational read ports (r_en1/reg1/r_data1, r_en2/reg2/r_data2);
  - one write port (w_en, w_addr, w_data).
  - A read with its enable low returns 0.
- The ALU is combinational logic in anna_exec.

## Test plan
- Reset, then addi r1,r0,5 at pc=0 → rd_prime=5, pc_prime=1; r1=5 next cycle.
- r1=0x0003, r2=0x0005, sub r3,r1,r2 → r3=0xFFFE. Then not r4,r3 → 0x0001.
- addi r0,r0,7 → r0 still reads 0. lui r1,0xAB with r1=0x0012 → r1=0xAB12.
- pc=0x0010:
  - r2=0, bez r2,−2 → pc_prime=0x000F.
  - r2=1, bez r2,−2 → pc_prime=0x0011.
  - jalr r5,r6 with r5=0x0100 → pc_prime=0x0100, r6=0x0011.
- shf r1,r2,−1 with r2=0x8000 → 0xC000. lw r3,r1,2 with mem_r_data=0xBEEF → mem_addr_o=r1+2, r3=0xBEEF.
- out r2 with r2=0x1234 → out_valid pulses once, out_data=0x1234. Then out r0 → halt=1, and a later addi has no effect. Reset clears halt.
